serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial N-bit subtractor with a start/done handshake, complementing the ripple-carry adder datapath. It computes D = A − B one bit per clock, LSB first, through a single full-subtractor cell, and reports the final borrow. It trades latency for area in arithmetic paths that need subtraction without a full-width combinational borrow chain.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  minuend, captured on the accepting edge
- B  in  WIDTH  subtrahend, captured on the accepting edge
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  single-cycle pulse when D/Bo are updated
- D  out  WIDTH  difference A − B mod 2^WIDTH
- Bo  out  1  final borrow (1 iff A < B, unsigned)

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE: on `start`=1, load the a_sh and b_sh shift registers from A and B. Clear the internal borrow and the bit counter. Go to SHIFT.
  - SHIFT, once per edge:
    - Feed the cell x = a_sh[0], y = b_sh[0], bin = borrow.
    - Shift a_sh and b_sh right.
    - Shift the result register right, inserting the cell's d at the MSB.
    - Register the cell's bout into borrow and increment the counter.
    - After the WIDTH-th bit, go to DONE.
  - DONE: `done`=1 for this cycle only. Unconditionally return to IDLE on the next edge.
- Cell equations: d = x^y^bin; bout = (~x & y) | (~(x^y) & bin).
- Output update:
  - D and Bo load from the result register and final borrow on the edge that enters DONE.
  - Between operations they hold their values until the next DONE.
- Ignored inputs:
  - `start` is ignored in SHIFT and DONE. No queuing: the requester must re-assert `start` in IDLE.
  - A and B are don't-care except on the accepting edge. Changes mid-operation have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Signed overflow is not reported.

## Timing
- Reset values, applied asynchronously: state = IDLE, busy = 0, done = 0, D = 0, Bo = 0. The shift registers, counter and borrow are cleared.
- Latency, with edge 0 being the edge that samples `start`=1 in IDLE:
  - busy rises after edge 0.
  - Bits are processed on edges 1..WIDTH.
  - done = 1 and D/Bo are valid after edge WIDTH.
  - busy falls after edge WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is edge WIDTH+2, with `start` held high through it.
- `start` held continuously high re-triggers every WIDTH+2 cycles.
- Reset mid-operation aborts without a `done` pulse. D and Bo return to 0.
- Reset asserted in the same cycle as an accepting `start`: reset wins and nothing is captured.

## Structure
- Shared package holds:
  - state encodings ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2;
  - the counter width, $clog2(WIDTH+1).
- Sub-module `full_subtractor` (ports x, y, bin, d, bout) is instantiated once. It is the serial counterpart of the existing full-adder cell.
- Top level contains:
  - the FSM;
  - the WIDTH-bit a_sh, b_sh and result shift registers;
  - the borrow flop, the counter, and the D/Bo output registers.

## Test plan
- A=5, B=3, `start` one cycle → done exactly 4 cycles after the accept edge; D=2, Bo=0; busy high for 5 cycles.
- A=3, B=5 → D=14 (4'b1110), Bo=1. Edge case A=0, B=1 → D=15, Bo=1.
- Sweep all 256 (A,B) pairs back-to-back with `start` held high → each result matches (A−B) mod 16 and A<B. There are exactly 6 cycles between accepts.
- Pulse `start` and change A/B during SHIFT → result reflects the originally captured operands; no second done.
- Assert `rst` on the 2nd SHIFT cycle → busy, done, D and Bo drop to 0 immediately; no done follows. A new `start` afterwards completes normally.
- A=15, B=15, then A=8, B=7 → D=0, Bo=0, then D=1, Bo=0. D holds 0 between the two done pulses.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The counter must be able to represent 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first through one
// full-subtractor cell, with start/busy/done handshake and final borrow Bo.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;
    logic             cell_d;
    logic             cell_bout;

    full_subtractor u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bo_d     = bo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d    = {cell_d, res_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                // The last bit goes straight into the outputs on the edge entering DONE.
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bo_d    = cell_bout;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bo_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bo_q     <= bo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = diff_q;
    assign Bo   = bo_q;

endmodule
